// File: rtl/imem_pkg.sv
// Shared constants, state encoding and address helpers for the synchronous
// instruction memory.
package imem_pkg;

   localparam logic [31:0] NOP_WORD = 32'h00000013;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   // True when a byte address lands inside a memory of 'depth' 32-bit words.
   // The full address takes part, so high bits never alias back into range.
   function automatic logic word_in_range(input logic [31:0] addr,
                                          input int unsigned depth);
      logic [33:0] limit;
      limit = 34'(depth) << 2;
      return (34'(addr) < limit);
   endfunction

endpackage

// File: rtl/imem_bank.sv
// DEPTH x 32 storage array: one synchronous read port and one byte-lane
// write port. A same-edge read of a word being written returns the old word.
module imem_bank #(
   parameter int unsigned DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [31:0]              rd_data,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [31:0]              wr_data,
   input  logic [3:0]               wr_be
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
      for (int i = 0; i < 4; i++) begin
         if (wr_en && wr_be[i]) begin
            mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/imem_sync.sv
// Byte-addressed instruction memory with registered 1-cycle fetch, stall
// hold, loader write port and a NOP-fill sequence after reset.
//
// state | meaning
// INIT  | writing NOP_WORD into word[cnt_q], one word per cycle; fetch/load ignored
// RUN   | fill complete (or skipped); fetch and loader writes accepted
module imem_sync #(
   parameter int unsigned DEPTH      = 256,
   parameter logic [31:0] NOP_WORD   = imem_pkg::NOP_WORD,
   parameter bit          INIT_CLEAR = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        rd_en,
   input  logic        stall,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        fault,
   input  logic        ld_we,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   input  logic [3:0]  ld_be,
   output logic        ready
);

   import imem_pkg::*;

   localparam int unsigned      ADDR_W   = $clog2(DEPTH);
   localparam logic [ADDR_W:0]  CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              ready_q;
   logic              valid_q, fault_q, use_ram_q;

   logic              pc_ok;
   logic              fetch_go;
   logic              bank_rd_en;
   logic [31:0]       bank_q;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [3:0]        wr_be;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT_CLEAR ? INIT : RUN;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= (state_d == RUN);
      end
   end

   // During INIT the fill owns the write port; in RUN the loader does.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_addr = ld_addr[ADDR_W+1:2];
      wr_data = ld_data;
      wr_be   = ld_be;
      unique case (state_q)
         INIT: begin
            wr_en   = 1'b1;
            wr_addr = cnt_q[ADDR_W-1:0];
            wr_data = NOP_WORD;
            wr_be   = 4'hF;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            wr_en = ld_we && ready_q && word_in_range(ld_addr, DEPTH);
         end
         default: state_d = INIT;
      endcase
      if (reset) begin
         wr_en = 1'b0;
      end
   end

   assign pc_ok      = (pc[1:0] == 2'b00) && word_in_range(pc, DEPTH);
   assign fetch_go   = ready_q && rd_en && !stall && !reset;
   assign bank_rd_en = fetch_go && pc_ok;

   imem_bank #(
      .DEPTH (DEPTH)
   ) u_bank (
      .clk     (clk),
      .rd_en   (bank_rd_en),
      .rd_addr (pc[ADDR_W+1:2]),
      .rd_data (bank_q),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_be   (wr_be)
   );

   // The RAM read register cannot be reset, so use_ram_q steers instr to
   // NOP_WORD after reset and after a faulting fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         fault_q   <= 1'b0;
         use_ram_q <= 1'b0;
      end else if (fetch_go) begin
         valid_q   <= 1'b1;
         fault_q   <= !pc_ok;
         use_ram_q <= pc_ok;
      end else if (!stall) begin
         valid_q   <= 1'b0;
         fault_q   <= 1'b0;
      end
   end

   assign instr       = use_ram_q ? bank_q : NOP_WORD;
   assign instr_valid = valid_q;
   assign fault       = fault_q;
   assign ready       = ready_q;

endmodule

// File: tb/tb_imem_sync.sv
// Directed bench for imem_sync at DEPTH=8: fill timing, loads, partial writes,
// faults, stall hold, read-before-write and reset during fill.
module tb_imem_sync;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        rd_en;
   logic        stall;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fault;
   logic        ld_we;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic [3:0]  ld_be;
   logic        ready;

   int vectors    = 0;
   int miscompares = 0;

   imem_sync #(
      .DEPTH      (8),
      .NOP_WORD   (32'h00000013),
      .INIT_CLEAR (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .rd_en       (rd_en),
      .stall       (stall),
      .instr       (instr),
      .instr_valid (instr_valid),
      .fault       (fault),
      .ld_we       (ld_we),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_be       (ld_be),
      .ready       (ready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] e_instr,
                          input logic e_valid, input logic e_fault);
      check({tag, ".instr"}, instr, e_instr);
      check({tag, ".valid"}, 32'(instr_valid), 32'(e_valid));
      check({tag, ".fault"}, 32'(fault), 32'(e_fault));
   endtask

   task automatic fetch(input logic [31:0] a);
      rd_en = 1'b1;
      pc    = a;
      step();
      rd_en = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      ld_we   = 1'b1;
      ld_addr = a;
      ld_data = d;
      ld_be   = be;
      step();
      ld_we   = 1'b0;
   endtask

   initial begin
      reset = 1'b1; pc = '0; rd_en = 1'b0; stall = 1'b0;
      ld_we = 1'b0; ld_addr = '0; ld_data = '0; ld_be = '0;

      step();
      reset = 1'b0;
      chk_out("rst", NOP, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("fill_ready_lo%0d", i), 32'(ready), 32'd0);
         step();
      end
      check("fill_ready_hi", 32'(ready), 32'd1);

      fetch(32'h1C);
      chk_out("fetch_1c", NOP, 1'b1, 1'b0);

      load(32'h4, 32'h0062E233, 4'hF);
      fetch(32'h4);
      chk_out("load_full", 32'h0062E233, 1'b1, 1'b0);
      step();
      chk_out("idle_after", 32'h0062E233, 1'b0, 1'b0);

      load(32'h4, 32'h0000AB00, 4'b0010);
      fetch(32'h4);
      chk_out("load_part", 32'h0062AB33, 1'b1, 1'b0);

      fetch(32'h6);
      chk_out("mis_6", NOP, 1'b1, 1'b1);
      step();
      chk_out("fault_clear", NOP, 1'b0, 1'b0);
      fetch(32'h20);
      chk_out("oor_20", NOP, 1'b1, 1'b1);
      fetch(32'h8000_0000);
      chk_out("oor_hi", NOP, 1'b1, 1'b1);

      fetch(32'h4);
      chk_out("pre_stall", 32'h0062AB33, 1'b1, 1'b0);
      stall = 1'b1;
      rd_en = 1'b1;
      pc = 32'h6;  step(); chk_out("stall1", 32'h0062AB33, 1'b1, 1'b0);
      pc = 32'h20; step(); chk_out("stall2", 32'h0062AB33, 1'b1, 1'b0);
      pc = 32'h0;  step(); chk_out("stall3", 32'h0062AB33, 1'b1, 1'b0);
      stall = 1'b0;
      rd_en = 1'b0;

      ld_we = 1'b1; ld_addr = 32'h4; ld_data = 32'hDEADBEEF; ld_be = 4'hF;
      fetch(32'h4);
      ld_we = 1'b0;
      chk_out("rbw_old", 32'h0062AB33, 1'b1, 1'b0);
      fetch(32'h4);
      chk_out("rbw_new", 32'hDEADBEEF, 1'b1, 1'b0);

      stall = 1'b1;
      load(32'h8, 32'h11223344, 4'hF);
      stall = 1'b0;
      fetch(32'h8);
      chk_out("stall_ld", 32'h11223344, 1'b1, 1'b0);
      load(32'h8, 32'hFFFFFFFF, 4'h0);
      fetch(32'h8);
      chk_out("be_zero", 32'h11223344, 1'b1, 1'b0);
      load(32'h20, 32'hCAFEF00D, 4'hF);
      fetch(32'h0);
      chk_out("ld_oor", NOP, 1'b1, 1'b0);

      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_out("rst_run", NOP, 1'b0, 1'b0);
      check("rst_run_ready", 32'(ready), 32'd0);
      step(); step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      ld_we = 1'b1; ld_addr = 32'hC; ld_data = 32'h12345678; ld_be = 4'hF;
      rd_en = 1'b1; pc = 32'h4;
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("refill_ready_lo%0d", i), 32'(ready), 32'd0);
         check($sformatf("refill_valid_lo%0d", i), 32'(instr_valid), 32'd0);
         step();
      end
      ld_we = 1'b0;
      rd_en = 1'b0;
      check("refill_ready_hi", 32'(ready), 32'd1);
      fetch(32'hC);
      chk_out("init_ld_ign", NOP, 1'b1, 1'b0);
      fetch(32'h4);
      chk_out("refill_w1", NOP, 1'b1, 1'b0);
      fetch(32'h8);
      chk_out("refill_w2", NOP, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
